// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   M-stage memory access controller. It decodes one load/store per request,
//   flags misaligned addresses, drives a single-outstanding request/response
//   bus, forms the extended load result or SC status, holds the pipeline while
//   an access is in flight and maintains the LL/SC link bit.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid, l_s_type      instruction valid + one-hot op {ll,sc,lw,lh,lhu,lb,lbu,sw,sh,sb}
//   addr, wdata_rt           effective address, store data
//   flush, eret              pipeline flush, eret commit (clears link bit)
//   data_*                   bus request side (req/wr/size/addr/wdata) and
//                            response side (addr_ok/data_ok/rdata)
//   result, result_valid     completion value and one-cycle pulse
//   stall                    hold pipeline
//   adel, ades, badvaddr     load/store address error and faulting address
//   llbit                    link bit
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [9:0]  l_s_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_rt,
  input  logic        flush,
  input  logic        eret,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        stall,
  output logic        adel,
  output logic        ades,
  output logic [31:0] badvaddr,
  output logic        llbit
);

  localparam int unsigned T_LL  = 9;
  localparam int unsigned T_SC  = 8;
  localparam int unsigned T_LW  = 7;
  localparam int unsigned T_LH  = 6;
  localparam int unsigned T_LHU = 5;
  localparam int unsigned T_LB  = 4;
  localparam int unsigned T_LBU = 3;
  localparam int unsigned T_SW  = 2;
  localparam int unsigned T_SH  = 1;
  localparam int unsigned T_SB  = 0;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  // True when exactly one op bit is set; anything else is an ignored encoding.
  function automatic logic onehot10(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  state_t      state_q, state_d;
  logic        llbit_q, llbit_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  logic [9:0]  type_q, type_d;
  logic        killed_q, killed_d;

  logic        valid_s, word_s, half_s, load_s, mis_s;
  logic        sc_blocked_s, go_s, sc_fail_s;
  logic        capture_s, complete_s, report_s;
  logic [7:0]  byte_sel_s;
  logic [15:0] half_sel_s;
  logic [31:0] done_res_s;

  assign valid_s = req_valid & onehot10(l_s_type);
  assign word_s  = l_s_type[T_LL] | l_s_type[T_SC] | l_s_type[T_LW] | l_s_type[T_SW];
  assign half_s  = l_s_type[T_LH] | l_s_type[T_LHU] | l_s_type[T_SH];
  assign load_s  = l_s_type[T_LL] | l_s_type[T_LW] | l_s_type[T_LH] |
                   l_s_type[T_LHU] | l_s_type[T_LB] | l_s_type[T_LBU];
  assign mis_s   = valid_s & ((word_s & (addr[1:0] != 2'b00)) | (half_s & addr[0]));
  // An SC without a valid link cannot succeed, so it never reaches the bus.
  assign sc_blocked_s = l_s_type[T_SC] & ~llbit_q;
  assign go_s         = valid_s & ~flush & ~mis_s & ~sc_blocked_s;
  assign sc_fail_s    = (state_q == IDLE) & valid_s & ~flush & ~mis_s & sc_blocked_s;

  // Next-state logic and issue/completion events.
  always_comb begin
    state_d    = state_q;
    capture_s  = 1'b0;
    complete_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_s) begin
          state_d   = REQ;
          capture_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            state_d    = IDLE;
            complete_s = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (data_data_ok) begin
          state_d    = IDLE;
          complete_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the bus request at issue; it stays frozen until the next issue.
  always_comb begin
    size_d  = size_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    type_d  = type_q;
    if (capture_s) begin
      size_d  = word_s ? 2'd2 : (half_s ? 2'd1 : 2'd0);
      wr_d    = ~load_s;
      addr_d  = word_s ? {addr[31:2], 2'b00} : addr;
      wdata_d = l_s_type[T_SB] ? {4{wdata_rt[7:0]}} :
                (l_s_type[T_SH] ? {2{wdata_rt[15:0]}} : wdata_rt);
      off_d   = addr[1:0];
      type_d  = l_s_type;
    end else begin
      off_d = off_q;
    end
  end

  // The bus cannot cancel, so a flush after issue only marks the access dead;
  // a flush in the completion cycle itself also kills the report.
  always_comb begin
    killed_d = (state_q != IDLE) & ~complete_s & (killed_q | flush);
    report_s = complete_s & ~(killed_q | flush);
  end

  // Link bit: eret has priority over an LL completing in the same cycle.
  always_comb begin
    llbit_d = llbit_q;
    if (eret) begin
      llbit_d = 1'b0;
    end else if (report_s & type_q[T_LL]) begin
      llbit_d = 1'b1;
    end else if (report_s & type_q[T_SC]) begin
      llbit_d = 1'b0;
    end else begin
      llbit_d = llbit_q;
    end
  end

  // Lane select and extension of the returned data using the captured offset.
  always_comb begin
    byte_sel_s = 8'd0;
    case (off_q)
      2'd0:    byte_sel_s = data_rdata[7:0];
      2'd1:    byte_sel_s = data_rdata[15:8];
      2'd2:    byte_sel_s = data_rdata[23:16];
      2'd3:    byte_sel_s = data_rdata[31:24];
      default: byte_sel_s = data_rdata[7:0];
    endcase
    half_sel_s = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    if (type_q[T_LB]) begin
      done_res_s = {{24{byte_sel_s[7]}}, byte_sel_s};
    end else if (type_q[T_LBU]) begin
      done_res_s = {24'd0, byte_sel_s};
    end else if (type_q[T_LH]) begin
      done_res_s = {{16{half_sel_s[15]}}, half_sel_s};
    end else if (type_q[T_LHU]) begin
      done_res_s = {16'd0, half_sel_s};
    end else if (type_q[T_LW] | type_q[T_LL]) begin
      done_res_s = data_rdata;
    end else if (type_q[T_SC]) begin
      done_res_s = 32'd1;
    end else begin
      done_res_s = 32'd0;
    end
  end

  // Combinational outputs, forced to zero while reset is asserted.
  always_comb begin
    result       = 32'd0;
    result_valid = 1'b0;
    stall        = 1'b0;
    adel         = 1'b0;
    ades         = 1'b0;
    badvaddr     = 32'd0;
    if (!rst) begin
      adel     = mis_s & load_s;
      ades     = mis_s & ~load_s;
      badvaddr = mis_s ? addr : 32'd0;
      stall    = ((state_q == IDLE) & go_s) | ((state_q != IDLE) & ~complete_s);
      if (sc_fail_s) begin
        result_valid = 1'b1;
        result       = 32'd0;
      end else if (report_s) begin
        result_valid = 1'b1;
        result       = done_res_s;
      end else begin
        result_valid = 1'b0;
      end
    end else begin
      stall = 1'b0;
    end
  end

  assign data_req   = (state_q == REQ);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign llbit      = llbit_q;

  // State and captured-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      llbit_q  <= 1'b0;
      size_q   <= 2'd0;
      wr_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      off_q    <= 2'd0;
      type_q   <= 10'd0;
      killed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      llbit_q  <= llbit_d;
      size_q   <= size_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      off_q    <= off_d;
      type_q   <= type_d;
      killed_q <= killed_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver pushes expected bus
// requests and results into queues, a negedge monitor pops and compares.
module tb_mem_access_ctrl;
  logic        clk, rst, req_valid, flush, eret;
  logic [9:0]  l_s_type;
  logic [31:0] addr, wdata_rt;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata, result, badvaddr;
  logic        result_valid, stall, adel, ades, llbit;

  localparam int OP_LL = 9, OP_SC = 8, OP_LW = 7, OP_LH = 6, OP_LHU = 5;
  localparam int OP_LB = 4, OP_LBU = 3, OP_SW = 2, OP_SH = 1, OP_SB = 0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] res_q[$];
  bus_t        last_bus;
  logic [31:0] last_result;
  bit          llbit_m;
  int          vectors = 0;
  int          miscompares = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .l_s_type(l_s_type),
    .addr(addr), .wdata_rt(wdata_rt), .flush(flush), .eret(eret),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .result(result), .result_valid(result_valid),
    .stall(stall), .adel(adel), .ades(ades), .badvaddr(badvaddr), .llbit(llbit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_load(input int op);
    return op inside {OP_LL, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
  endfunction

  function automatic int width_of(input int op);
    if (op inside {OP_LL, OP_SC, OP_LW, OP_SW}) return 4;
    if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
    return 1;
  endfunction

  // What the bus should see for an access: aligned word address, replicated store lanes.
  function automatic bus_t model_bus(input int op, input logic [31:0] a, input logic [31:0] wd);
    bus_t b;
    int   w;
    w       = width_of(op);
    b.wr    = !is_load(op);
    b.size  = (w == 4) ? 2'd2 : ((w == 2) ? 2'd1 : 2'd0);
    b.addr  = (w == 4) ? (a & 32'hFFFF_FFFC) : a;
    b.wdata = (w == 1) ? (wd & 32'h0000_00FF) * 32'h0101_0101 :
              ((w == 2) ? (wd & 32'h0000_FFFF) * 32'h0001_0001 : wd);
    return b;
  endfunction

  // Value the pipeline should receive when the access completes.
  function automatic logic [31:0] model_result(input int op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int          off;
    off = int'(a % 32'd4);
    case (op)
      OP_LB, OP_LBU: begin
        v = (rd >> (8 * off)) & 32'h0000_00FF;
        if (op == OP_LB && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      OP_LH, OP_LHU: begin
        v = (rd >> (16 * (off / 2))) & 32'h0000_FFFF;
        if (op == OP_LH && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      OP_LW, OP_LL: v = rd;
      OP_SC:        v = 32'd1;
      default:      v = 32'd0;
    endcase
    return v;
  endfunction

  // Monitor: every data_req cycle must match the queued request; every result pulse
  // must match the queued result.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_req) begin
        if (bus_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: data_req=1 at addr 0x%08h, expected no request", data_addr);
        end else begin
          chk("bus_wr", 32'(data_wr), 32'(bus_q[0].wr));
          chk("bus_size", 32'(data_size), 32'(bus_q[0].size));
          chk("bus_addr", data_addr, bus_q[0].addr);
          if (bus_q[0].wr) chk("bus_wdata", data_wdata, bus_q[0].wdata);
          if (data_addr_ok) last_bus = bus_q.pop_front();
        end
      end
      if (result_valid) begin
        if (res_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: result_valid=1 result 0x%08h, expected no pulse", result);
        end else begin
          chk("result", result, res_q[0]);
          last_result = res_q.pop_front();
        end
      end
    end
  end

  task automatic cyc(input string tag, input bit exp_stall);
    @(negedge clk);
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; l_s_type = 10'd0; flush = 1'b0; eret = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  // One instruction: a_dly REQ cycles before addr_ok, d_dly cycles from addr_ok to
  // data_ok, flush pulsed at busy cycle kill_k (0 = none), eret in completion cycle.
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int a_dly, input int d_dly,
                       input int kill_k, input bit eret_c, input bit flush_idle);
    int w, n;
    bit killed;
    w = width_of(op);
    req_valid = 1'b1; l_s_type = 10'd1 << op; addr = a; wdata_rt = wd;
    flush = flush_idle; eret = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = $urandom;
    if ((a % 32'(w)) != 32'd0) begin
      @(negedge clk);
      chk("adel", 32'(adel), 32'(is_load(op)));
      chk("ades", 32'(ades), 32'(!is_load(op)));
      chk("badvaddr", badvaddr, a);
      chk("fault_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
    end else if (flush_idle) begin
      cyc("flush_idle", 1'b0);
    end else if (op == OP_SC && !llbit_m) begin
      res_q.push_back(32'd0);
      cyc("sc_fail", 1'b0);
    end else begin
      n = a_dly + 1 + d_dly;
      killed = (kill_k >= 1) && (kill_k <= n);
      bus_q.push_back(model_bus(op, a, wd));
      if (!killed) res_q.push_back(model_result(op, a, rd));
      cyc("issue", 1'b1);
      for (int i = 1; i <= n; i++) begin
        data_addr_ok = (i == a_dly + 1);
        data_data_ok = (i == n);
        data_rdata   = (i == n) ? rd : $urandom;
        flush        = (i == kill_k);
        eret         = eret_c && (i == n);
        cyc("busy", i != n);
      end
      if (eret_c) llbit_m = 1'b0;
      else if (!killed && op == OP_LL) llbit_m = 1'b1;
      else if (!killed && op == OP_SC) llbit_m = 1'b0;
    end
    idle_inputs();
    @(negedge clk);
    chk("llbit", 32'(llbit), 32'(llbit_m));
    @(posedge clk);
    #1;
  endtask

  task automatic do_invalid(input logic [9:0] t, input logic [31:0] a);
    req_valid = 1'b1; l_s_type = t; addr = a; wdata_rt = $urandom;
    @(negedge clk);
    chk("inv_adel", 32'(adel), 32'd0);
    chk("inv_ades", 32'(ades), 32'd0);
    chk("inv_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    cyc("inv_after", 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_req"}, 32'(data_req), 32'd0);
    chk({tag, "_data_addr"}, data_addr, 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_adel"}, 32'(adel), 32'd0);
    chk({tag, "_ades"}, 32'(ades), 32'd0);
    chk({tag, "_badvaddr"}, badvaddr, 32'd0);
    chk({tag, "_llbit"}, 32'(llbit), 32'd0);
  endtask

  int          op, a_dly, d_dly, kill_k;
  bit          eret_c, flush_idle;
  logic [31:0] a, wd, rd;
  logic [9:0]  t;

  initial begin
    llbit_m = 1'b0;
    rst = 1'b1; idle_inputs();
    data_rdata = 32'd0; wdata_rt = 32'd0;
    // Misaligned lw held during reset: outputs must still read zero.
    req_valid = 1'b1; l_s_type = 10'd1 << OP_LW; addr = 32'h0000_0006;
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0; idle_inputs();
    cyc("post_reset", 1'b0);

    // lb at 0x103, same-cycle addr_ok/data_ok.
    do_op(OP_LB, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 0, 0, 1'b0, 1'b0);
    chk("lb_result", last_result, 32'hFFFF_FF80);
    chk("lb_addr", last_bus.addr, 32'h0000_0103);
    // sh at 0x2, addr_ok after 2 extra cycles, data_ok one later.
    do_op(OP_SH, 32'h0000_0002, 32'h1234_ABCD, 32'd0, 2, 1, 0, 1'b0, 1'b0);
    chk("sh_wdata", last_bus.wdata, 32'hABCD_ABCD);
    // lw at 0x6: address error, no request.
    do_op(OP_LW, 32'h0000_0006, 32'd0, 32'd0, 0, 0, 0, 1'b0, 1'b0);
    // ll / sc / repeated sc.
    do_op(OP_LL, 32'h0000_0040, 32'd0, 32'h1111_2222, 0, 1, 0, 1'b0, 1'b0);
    chk("ll_llbit", 32'(llbit), 32'd1);
    do_op(OP_SC, 32'h0000_0040, 32'h0000_0005, 32'd0, 1, 0, 0, 1'b0, 1'b0);
    chk("sc_result", last_result, 32'd1);
    chk("sc_wdata", last_bus.wdata, 32'h0000_0005);
    chk("sc_llbit", 32'(llbit), 32'd0);
    do_op(OP_SC, 32'h0000_0040, 32'h0000_0005, 32'd0, 0, 0, 0, 1'b0, 1'b0);
    chk("sc2_result", last_result, 32'd0);
    // ll completing with eret: eret wins.
    do_op(OP_LL, 32'h0000_0080, 32'd0, 32'h0, 0, 0, 0, 1'b0, 1'b0);
    do_op(OP_LL, 32'h0000_0084, 32'd0, 32'h0, 0, 2, 0, 1'b1, 1'b0);
    chk("eret_llbit", 32'(llbit), 32'd0);
    // lw flushed in WAIT, data_ok two cycles later.
    do_op(OP_LW, 32'h0000_0008, 32'd0, 32'hDEAD_BEEF, 0, 3, 2, 1'b0, 1'b0);
    // flush in IDLE, then zero-hot and multi-hot types.
    do_op(OP_LW, 32'h0000_0010, 32'd0, 32'd0, 0, 0, 0, 1'b0, 1'b1);
    do_invalid(10'd0, 32'h0000_0001);
    do_invalid(10'b10_1000_0000, 32'h0000_0002);

    // Reset raised while in WAIT, with a link held.
    do_op(OP_LL, 32'h0000_0100, 32'd0, 32'd0, 0, 0, 0, 1'b0, 1'b0);
    req_valid = 1'b1; l_s_type = 10'd1 << OP_LW; addr = 32'h0000_0010;
    bus_q.push_back(model_bus(OP_LW, 32'h0000_0010, 32'd0));
    cyc("rst_issue", 1'b1);
    data_addr_ok = 1'b1;
    cyc("rst_req", 1'b1);
    data_addr_ok = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    llbit_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; idle_inputs();
    @(negedge clk);
    chk("post_rst_req", 32'(data_req), 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    do_op(OP_LHU, 32'h0000_0012, 32'd0, 32'hBEEF_0000, 1, 1, 0, 1'b0, 1'b0);

    for (int k = 0; k < 200; k++) begin
      op = $urandom_range(9, 0);
      if ($urandom_range(9, 0) < 3) op = $urandom_range(9, 8);
      a = $urandom;
      if ($urandom_range(9, 0) < 7) a = a & 32'hFFFF_FFFC;
      wd = $urandom; rd = $urandom;
      a_dly = $urandom_range(3, 0); d_dly = $urandom_range(3, 0);
      kill_k = ($urandom_range(7, 0) == 0) ? $urandom_range(5, 1) : 0;
      eret_c = ($urandom_range(9, 0) == 0);
      flush_idle = ($urandom_range(11, 0) == 0);
      do_op(op, a, wd, rd, a_dly, d_dly, kill_k, eret_c, flush_idle);
      if (k % 25 == 0) begin
        t = (10'd3 << $urandom_range(8, 0)) | 10'($urandom);
        do_invalid(t, $urandom);
      end
    end

    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
